// File: rtl/ball_engine.sv
// Pong ball motion/collision engine; all motion advances on frame_tick.
// Optional build macro: BALL_SPEEDUP_EN (speed ramps on paddle hits).
module ball_engine #(
  parameter int H_SCREEN  = 640,
  parameter int V_SCREEN  = 480,
  parameter int BORDER    = 10,
  parameter int BALL_SIZE = 10,
  parameter int P_OFFSET  = 20,
  parameter int P_WIDTH   = 8,
  parameter int P_HIGH    = 96,
  parameter int SPEED     = 2
`ifdef BALL_SPEEDUP_EN
  ,
  parameter int MAX_SPEED = 6
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic       serve_side,
  input  logic [9:0] p1_y,
  input  logic [9:0] p2_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       moving,
  output logic       left_hit,
  output logic       right_hit,
  output logic       paddle_hit,
  output logic [3:0] speed
);

  localparam logic [10:0] P1_X  = 11'(BORDER + P_OFFSET);
  localparam logic [10:0] P2_X  = 11'(H_SCREEN - BORDER - P_OFFSET - P_WIDTH);
  localparam logic [10:0] L_SRV = 11'(BORDER + P_OFFSET + P_WIDTH);
  localparam logic [10:0] R_SRV = 11'(H_SCREEN - BORDER - P_OFFSET
                                      - P_WIDTH - BALL_SIZE);
  localparam logic [10:0] Y_SRV = 11'((V_SCREEN - BALL_SIZE) / 2);
  localparam logic [10:0] Y_MIN = 11'(BORDER);
  localparam logic [10:0] Y_MAX = 11'(V_SCREEN - BORDER - BALL_SIZE);
  localparam logic [10:0] X_RW  = 11'(H_SCREEN - BORDER - BALL_SIZE);
  localparam logic [10:0] BS    = 11'(BALL_SIZE);
  localparam logic [10:0] PW    = 11'(P_WIDTH);
  localparam logic [10:0] PH    = 11'(P_HIGH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    SCORED = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [9:0]  r_x, r_y, w_x_nxt, w_y_nxt;
  logic        r_dx, r_dy, w_dx_nxt, w_dy_nxt;
  logic        r_lhit, r_rhit, r_phit;
  logic        w_lhit, w_rhit, w_phit, w_srv, w_score;
  logic [3:0]  r_speed;
  logic [10:0] w_x, w_y, w_p1, w_p2, w_spd;
  logic        w_ov1, w_ov2;

  assign w_x   = {1'b0, r_x};
  assign w_y   = {1'b0, r_y};
  assign w_p1  = {1'b0, p1_y};
  assign w_p2  = {1'b0, p2_y};
  assign w_spd = {7'd0, r_speed};
  assign w_ov1 = (w_y + BS > w_p1) && (w_y < w_p1 + PH);
  assign w_ov2 = (w_y + BS > w_p2) && (w_y < w_p2 + PH);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, next ball kinematics and event pulses
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_dx_nxt    = r_dx;
    w_dy_nxt    = r_dy;
    w_lhit      = 1'b0;
    w_rhit      = 1'b0;
    w_phit      = 1'b0;
    w_srv       = 1'b0;
    w_score     = 1'b0;
    unique case (r_state)
      MOVE: begin
        if (frame_tick) begin
          if (!r_dx) begin
            if (w_x + BS >= P2_X && w_x < P2_X + PW && w_ov2) begin
              w_dx_nxt = 1'b1;
              w_x_nxt  = R_SRV[9:0];
              w_phit   = 1'b1;
            end else if (w_x >= X_RW - w_spd) begin
              w_rhit  = 1'b1;
              w_score = 1'b1;
            end else begin
              w_x_nxt = 10'(w_x + w_spd);
            end
          end else begin
            if (w_x <= L_SRV && w_x + BS > P1_X && w_ov1) begin
              w_dx_nxt = 1'b0;
              w_x_nxt  = L_SRV[9:0];
              w_phit   = 1'b1;
            end else if (w_x <= Y_MIN + w_spd) begin
              w_lhit  = 1'b1;
              w_score = 1'b1;
            end else begin
              w_x_nxt = 10'(w_x - w_spd);
            end
          end
          if (w_score) begin
            w_state_nxt = SCORED;
          end else if (!r_dy) begin
            if (w_y + w_spd >= Y_MAX) begin
              w_y_nxt  = Y_MAX[9:0];
              w_dy_nxt = 1'b1;
            end else begin
              w_y_nxt = 10'(w_y + w_spd);
            end
          end else begin
            if (w_y <= Y_MIN + w_spd) begin
              w_y_nxt  = Y_MIN[9:0];
              w_dy_nxt = 1'b0;
            end else begin
              w_y_nxt = 10'(w_y - w_spd);
            end
          end
        end
      end
      default: begin
        if (serve) begin
          w_state_nxt = MOVE;
          w_x_nxt     = serve_side ? R_SRV[9:0] : L_SRV[9:0];
          w_y_nxt     = Y_SRV[9:0];
          w_dx_nxt    = serve_side;
          w_dy_nxt    = 1'b0;
          w_srv       = 1'b1;
        end
      end
    endcase
  end

  // Ball position, direction and registered pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x    <= L_SRV[9:0];
      r_y    <= Y_SRV[9:0];
      r_dx   <= 1'b0;
      r_dy   <= 1'b0;
      r_lhit <= 1'b0;
      r_rhit <= 1'b0;
      r_phit <= 1'b0;
    end else begin
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_dx   <= w_dx_nxt;
      r_dy   <= w_dy_nxt;
      r_lhit <= w_lhit;
      r_rhit <= w_rhit;
      r_phit <= w_phit;
    end
  end

  // Speed: serve value, optionally ramped by paddle hits
  always_ff @(posedge clk) begin
    if (reset || w_srv) begin
      r_speed <= 4'(SPEED);
`ifdef BALL_SPEEDUP_EN
    end else if (w_phit && r_speed < 4'(MAX_SPEED)) begin
      r_speed <= r_speed + 4'd1;
`endif
    end
  end

  assign ball_x     = r_x;
  assign ball_y     = r_y;
  assign moving     = (r_state == MOVE);
  assign left_hit   = r_lhit;
  assign right_hit  = r_rhit;
  assign paddle_hit = r_phit;
  assign speed      = r_speed;

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine (default build, constant speed).
// Expected positions are hand-derived from the serve/bounce rules.
module tb_ball_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       serve = 1'b0;
  logic       serve_side = 1'b0;
  logic [9:0] p1_y = '0;
  logic [9:0] p2_y = '0;
  logic [9:0] ball_x, ball_y;
  logic       moving, left_hit, right_hit, paddle_hit;
  logic [3:0] speed;

  int n_chk = 0;
  int n_err = 0;

  ball_engine dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .serve      (serve),
    .serve_side (serve_side),
    .p1_y       (p1_y),
    .p2_y       (p2_y),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .moving     (moving),
    .left_hit   (left_hit),
    .right_hit  (right_hit),
    .paddle_hit (paddle_hit),
    .speed      (speed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      tick();
      @(negedge clk);
    end
  endtask

  task automatic do_serve(input logic side);
    serve      = 1'b1;
    serve_side = side;
    @(negedge clk);
    serve      = 1'b0;
  endtask

  task automatic chk_pos(input string tag, input int x, input int y);
    chk({tag, ".x"}, int'(ball_x), x);
    chk({tag, ".y"}, int'(ball_y), y);
  endtask

  initial begin
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_pos("rst", 38, 235);
    chk("rst.moving", int'(moving), 0);
    chk("rst.speed", int'(speed), 2);
    chk("rst.pulses", int'({left_hit, right_hit, paddle_hit}), 0);

    run(2);
    chk_pos("idle_tick", 38, 235);

    p1_y = 10'd0;
    p2_y = 10'd100;
    do_serve(1'b0);
    chk_pos("serve_l", 38, 235);
    chk("serve_l.moving", int'(moving), 1);

    run(3);
    chk_pos("t3", 44, 241);
    chk("t3.moving", int'(moving), 1);

    run(109);
    chk_pos("t112", 262, 459);
    run(1);
    chk_pos("t113_ymax", 264, 460);
    run(1);
    chk_pos("t114_yback", 266, 458);

    run(163);
    chk_pos("t277", 592, 132);
    chk("t277.phit", int'(paddle_hit), 0);

    tick();
    chk("p2_hit.pulse", int'(paddle_hit), 1);
    chk_pos("p2_hit", 592, 130);
    @(negedge clk);
    chk("p2_hit.end", int'(paddle_hit), 0);

    run(60);
    chk_pos("t338_ymin", 472, 10);

    run(229);
    chk_pos("t567", 14, 452);
    run(1);
    chk_pos("t568", 12, 450);
    chk("t568.moving", int'(moving), 1);

    tick();
    chk("lmiss.pulse", int'(left_hit), 1);
    chk("lmiss.rhit", int'(right_hit), 0);
    chk("lmiss.moving", int'(moving), 0);
    chk_pos("lmiss", 12, 450);
    @(negedge clk);
    chk("lmiss.end", int'(left_hit), 0);

    run(3);
    chk_pos("frozen", 12, 450);
    chk("frozen.lhit", int'(left_hit), 0);

    serve      = 1'b1;
    serve_side = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    serve      = 1'b0;
    frame_tick = 1'b0;
    chk_pos("serve_r_tick", 592, 235);
    chk("serve_r.moving", int'(moving), 1);
    chk("serve_r.speed", int'(speed), 2);

    run(1);
    chk_pos("serve_r_t1", 590, 237);

    do_serve(1'b0);
    chk_pos("serve_ign", 590, 237);
    chk("serve_ign.moving", int'(moving), 1);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_pos("rst_mid", 38, 235);
    chk("rst_mid.moving", int'(moving), 0);
    chk("rst_mid.speed", int'(speed), 2);

    p2_y = 10'd1000;
    do_serve(1'b0);
    run(290);
    chk_pos("t290", 618, 106);
    tick();
    chk("rmiss.pulse", int'(right_hit), 1);
    chk("rmiss.lhit", int'(left_hit), 0);
    chk("rmiss.phit", int'(paddle_hit), 0);
    chk("rmiss.moving", int'(moving), 0);
    chk_pos("rmiss", 618, 106);
    @(negedge clk);
    chk("rmiss.end", int'(right_hit), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
